gao_vio_er2: RTL and testbench
==============================

Name: gao_vio_er2

Overview:
- JTAG-to-fabric virtual input driver on the GW_JTAG ER2 user chain. ER1 carries the logic-analyser capture path; this block is the other direction: the host writes values into the design.
- Oversamples the JTAG control outputs in the system clock domain.
- Deserialises a parity-protected frame and drives a register (e.g. change_pwm) into the PWM/phased-array logic.
- Captures the current register value for readback on tdo_o.

Parameters:
- DATA_W, 8, width of the driven register.
- INIT, 0, reset value of dout.
- FRAME_W, DATA_W+3, fixed shift length: data + 2-bit cmd + parity (derived; do not override).

Ports:
- clk  in  1  system clock; must be at least 8x the tck frequency.
- rst_n  in  1  asynchronous active-low reset.
- tck_i  in  1  JTAG tck from GW_JTAG tck_o.
- tdi_i  in  1  JTAG tdi from GW_JTAG tdi_o.
- enable_i  in  1  GW_JTAG enable_er2_o.
- shift_dr_capture_dr_i  in  1  GW_JTAG shift_dr_capture_dr_o.
- update_dr_i  in  1  GW_JTAG update_dr_o.
- tlr_i  in  1  GW_JTAG test_logic_reset_o.
- tdo_o  out  1  to GW_JTAG tdo_er2_i.
- dout  out  DATA_W  driven register.
- dout_valid  out  1  one-clk strobe when dout is written.
- pulse_o  out  DATA_W  one-clk strobe pattern.
- err_o  out  1  sticky frame error.
- err_cnt  out  8  saturating count of rejected frames.

Behaviour:
- Reset (rst_n low, async) clears everything to the following values:
  - dout=INIT; dout_valid=0; pulse_o=0; err_o=0; err_cnt=0; tdo_o=0.
  - FSM=IDLE; sr=0; bit_cnt=0.
  - All synchroniser flops = 0.
- Synchronisation:
  - tck_i, tdi_i, enable_i, shift_dr_capture_dr_i, update_dr_i and tlr_i each pass through a 2-FF synchroniser.
  - A third flop on tck and on update provides rising-edge detect (tck_rise, upd_rise).
  - tdi is taken from the synchronised copy in the same cycle as tck_rise.
- FSM has four states: IDLE, SHIFT, UPDATE, TLR.
  - IDLE: on tck_rise & en & shift, perform the capture edge:
    - sr <= {err_o, 2'b00, dout}; bit_cnt <= 0.
    - Go to SHIFT.
  - SHIFT: each tck_rise & en & shift:
    - tdo_o <= sr[0]; sr <= {tdi, sr[FRAME_W-1:1]}.
    - bit_cnt <= bit_cnt+1, saturating at FRAME_W+1.
    - upd_rise & en -> UPDATE.
    - en low without update -> IDLE, no effect on outputs.
  - UPDATE (one clk), then IDLE:
    - Frame is valid iff bit_cnt==FRAME_W and sr[FRAME_W-1] == XOR(sr[FRAME_W-2:0]) (even parity).
    - Bit order is LSB-first: data[0] shifted first, parity last. sr[DATA_W-1:0]=data, sr[DATA_W+1:DATA_W]=cmd.
  - Valid frame, by cmd:
    - 00 NOP.
    - 01 WRITE: dout <= data; dout_valid=1 for 1 clk.
    - 10 PULSE: pulse_o=data for 1 clk; dout unchanged.
    - 11 CLEAR: err_o <= 0 and err_cnt <= 0.
  - Invalid frame (short, long, or parity error):
    - Outputs unchanged; err_o <= 1; err_cnt += 1, saturating at 255.
  - TLR: sync tlr high from any state -> TLR. Stay there while high, then IDLE. A frame in progress is discarded without error; dout, err_o and err_cnt are preserved.
- Latency: dout, dout_valid and pulse_o change on the 4th clk edge after update_dr_i is first sampled high.
- Simultaneous events:
  - tck_rise and upd_rise in the same cycle: the shift is applied first (counted), then UPDATE.
  - tlr has priority over everything.
- upd_rise in IDLE (update without shift) is ignored: no error and no strobe.
- Readback: with the capture load above, a host that shifts FRAME_W bits receives dout[0..DATA_W-1], then 0,0, then err_o, on tdo.

Decomposition:
- Package gao_vio_pkg holds:
  - State enum {IDLE, SHIFT, UPDATE, TLR}.
  - Command constants CMD_NOP=2'b00, CMD_WRITE=2'b01, CMD_PULSE=2'b10, CMD_CLEAR=2'b11.
  - Function frame_w(DATA_W).
- One sub-module, gao_vio_sync: a 2-FF synchroniser plus rising-edge detect, instantiated per JTAG input. Edge output is used for tck and update only.

Test Plan (DATA_W=8, clk 50 MHz, tck 2 MHz JTAG BFM):
- Write 0xA5 (cmd 01, parity 1), 11 shifts, update -> dout=0xA5 four clks after update; dout_valid high exactly 1 clk; err_cnt=0.
- Readback after the previous step, shifting a NOP frame -> tdo sequence 1,0,1,0,0,1,0,1,0,0,0 (0xA5 LSB-first, then 0,0, then err_o=0); dout stays 0xA5.
- Parity-flipped write of 0x3C -> dout stays 0xA5; err_o=1; err_cnt=1. Then a 10-bit frame and a 12-bit frame -> err_cnt=3. Then CLEAR -> err_o=0, err_cnt=0.
- PULSE 0x0F -> pulse_o=0x0F for 1 clk, then 0x00; dout unchanged; no dout_valid.
- tlr asserted after 5 shifts, then released -> no error and no strobe; the next valid write 0x11 is applied normally.
- rst_n pulsed low mid-shift (asynchronous, not aligned to clk) -> dout=INIT immediately; FSM IDLE; a subsequent full write 0x77 succeeds.

Source files
------------

// File: rtl/gao_vio_er2_pkg.sv
// gao_vio_pkg: shared FSM states, frame commands and frame-length helper for gao_vio_er2
package gao_vio_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE, TLR} state_e;
  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_PULSE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
  // Frame is data + 2-bit cmd + even parity bit.
  function automatic int frame_w(input int data_w);
    return data_w + 3;
  endfunction
endpackage

// File: rtl/gao_vio_er2_if.sv
// gao_vio_er2_if: GW_JTAG ER2 user-chain signals
//   tck_i/tdi_i/enable_i/shift_dr_capture_dr_i/update_dr_i/tlr_i: JTAG controls into the block
//   tdo_o: readback data out of the block
//   master modport = JTAG primitive side, slave modport = gao_vio_er2
interface gao_vio_er2_if;
  logic tck_i;
  logic tdi_i;
  logic enable_i;
  logic shift_dr_capture_dr_i;
  logic update_dr_i;
  logic tlr_i;
  logic tdo_o;
  modport master (output tck_i, tdi_i, enable_i, shift_dr_capture_dr_i, update_dr_i, tlr_i, input tdo_o);
  modport slave (input tck_i, tdi_i, enable_i, shift_dr_capture_dr_i, update_dr_i, tlr_i, output tdo_o);
endinterface

// File: rtl/gao_vio_er2_sync.sv
// gao_vio_sync: 2-FF synchroniser with a third flop for rising-edge detect
//   clk, rst_n: system clock, async active-low reset
//   d_i: asynchronous input; q_o: synchronised level; rise_o: one-clk rising-edge strobe
module gao_vio_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);
  logic [2:0] s_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else s_q <= {s_q[1:0], d_i};
  end
  assign q_o    = s_q[1];
  assign rise_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/gao_vio_er2.sv
// gao_vio_er2: JTAG ER2 virtual input driver -- deserialises parity-protected frames into a fabric register
//   clk, rst_n: system clock (>= 8x tck), async active-low reset
//   jtag: GW_JTAG ER2 chain (slave modport), tdo_o carries readback of {err_o, 2'b00, dout}
//   dout/dout_valid: driven register and its one-clk write strobe
//   pulse_o: one-clk strobe pattern; err_o/err_cnt: sticky error and saturating rejected-frame count
module gao_vio_er2 import gao_vio_pkg::*; #(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] INIT   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  gao_vio_er2_if.slave      jtag,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] pulse_o,
  output logic              err_o,
  output logic [7:0]        err_cnt
);
  localparam int FRAME_W = frame_w(DATA_W);
  localparam int CW = $clog2(FRAME_W + 2);
  logic [5:0] raw, syn, rise;
  logic [5:0] unused_bits;
  logic tdi, en, shift, tlr, tck_rise, upd_rise;
  state_e state_q;
  logic [FRAME_W-1:0] sr_q;
  logic [CW-1:0] bit_cnt_q;
  logic tdo_q, dout_valid_q, err_q, frame_ok;
  logic [DATA_W-1:0] dout_q, pulse_q;
  logic [7:0] err_cnt_q;
  logic [1:0] cmd;
  assign raw = {jtag.tlr_i, jtag.update_dr_i, jtag.shift_dr_capture_dr_i, jtag.enable_i, jtag.tdi_i, jtag.tck_i};
  for (genvar i = 0; i < 6; i++) begin : g_sync
    gao_vio_sync u_sync (.clk(clk), .rst_n(rst_n), .d_i(raw[i]), .q_o(syn[i]), .rise_o(rise[i]));
  end
  // Only tck and update need edges; tck/update levels and other edges are unused.
  assign unused_bits = {syn[4], syn[0], rise[5], rise[3:1]};
  assign tdi      = syn[1];
  assign en       = syn[2];
  assign shift    = syn[3];
  assign tlr      = syn[5];
  assign tck_rise = rise[0];
  assign upd_rise = rise[4];
  assign cmd      = sr_q[DATA_W+1:DATA_W];
  // Exactly FRAME_W shifts and even parity over the whole frame.
  assign frame_ok = (bit_cnt_q == CW'(FRAME_W)) && (sr_q[FRAME_W-1] == ^sr_q[FRAME_W-2:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      tdo_q        <= 1'b0;
      dout_q       <= INIT;
      dout_valid_q <= 1'b0;
      pulse_q      <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      pulse_q      <= '0;
      if (tlr) state_q <= TLR;
      else begin
        case (state_q)
          IDLE: begin
            // Capture edge: load readback image, shifting starts on the next tck.
            if (tck_rise && en && shift) begin
              sr_q      <= {err_q, 2'b00, dout_q};
              bit_cnt_q <= '0;
              state_q   <= SHIFT;
            end
          end
          SHIFT: begin
            if (tck_rise && en && shift) begin
              tdo_q     <= sr_q[0];
              sr_q      <= {tdi, sr_q[FRAME_W-1:1]};
              bit_cnt_q <= (bit_cnt_q == CW'(FRAME_W + 1)) ? bit_cnt_q : bit_cnt_q + CW'(1);
            end
            if (upd_rise && en) state_q <= UPDATE;
            else if (!en) state_q <= IDLE;
          end
          UPDATE: begin
            state_q <= IDLE;
            if (!frame_ok) begin
              err_q     <= 1'b1;
              err_cnt_q <= (err_cnt_q == 8'hff) ? err_cnt_q : err_cnt_q + 8'd1;
            end else if (cmd == CMD_WRITE) begin
              dout_q       <= sr_q[DATA_W-1:0];
              dout_valid_q <= 1'b1;
            end else if (cmd == CMD_PULSE) begin
              pulse_q <= sr_q[DATA_W-1:0];
            end else if (cmd == CMD_CLEAR) begin
              err_q     <= 1'b0;
              err_cnt_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign jtag.tdo_o = tdo_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign pulse_o    = pulse_q;
  assign err_o      = err_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_gao_vio_er2.sv
// tb_gao_vio_er2: JTAG BFM driving gao_vio_er2 with a frame-level reference model and per-cycle output compare
module tb_gao_vio_er2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] dout, pulse_o, err_cnt;
  logic dout_valid, err_o;
  gao_vio_er2_if jtag();
  gao_vio_er2 #(.DATA_W(8), .INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .jtag(jtag), .dout(dout), .dout_valid(dout_valid),
    .pulse_o(pulse_o), .err_o(err_o), .err_cnt(err_cnt)
  );
  always #10 clk = ~clk;

  int total = 0, passed = 0;
  logic check_en = 1'b0;
  logic [7:0] exp_dout = 8'h00, exp_pulse = 8'h00, exp_cnt = 8'h00;
  logic exp_valid = 1'b0, exp_err = 1'b0;
  int pend = 0, pend_n = 0;
  logic [15:0] pend_bits = '0;
  int valid_seen = 0, pulse_seen = 0;
  logic [7:0] pulse_val = 8'h00;
  logic [10:0] rb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Frame-level effect: a frame takes hold as a whole, 4 clk edges after update is seen.
  task automatic model_apply();
    logic ok;
    ok = (pend_n == 11) && (pend_bits[10] == ^pend_bits[9:0]);
    if (!ok) begin
      exp_err = 1'b1;
      if (exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
    end else if (pend_bits[9:8] == 2'b01) begin
      exp_dout = pend_bits[7:0];
      exp_valid = 1'b1;
    end else if (pend_bits[9:8] == 2'b10) exp_pulse = pend_bits[7:0];
    else if (pend_bits[9:8] == 2'b11) begin
      exp_err = 1'b0;
      exp_cnt = 8'h00;
    end
  endtask

  always @(posedge clk) if (rst_n) begin
    exp_valid = 1'b0;
    exp_pulse = 8'h00;
    if (pend > 0) begin
      pend--;
      if (pend == 0) model_apply();
    end
  end

  always @(negedge clk) if (check_en) begin
    chk("dout", 32'(dout), 32'(exp_dout));
    chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
    chk("pulse_o", 32'(pulse_o), 32'(exp_pulse));
    chk("err_o", 32'(err_o), 32'(exp_err));
    chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    if (dout_valid) valid_seen++;
    if (|pulse_o) begin
      pulse_seen++;
      pulse_val = pulse_o;
    end
  end

  task automatic tck_pulse(input logic d, output logic t);
    jtag.tdi_i = d;
    #250 jtag.tck_i = 1'b1;
    #240 t = jtag.tdo_o;
    #10 jtag.tck_i = 1'b0;
  endtask

  // abort: 0 = normal update, 1 = tlr after cut shifts, 2 = async reset after cut shifts
  task automatic frame(input logic [15:0] bits, input int n, input int abort, input int cut, output logic [10:0] rbo);
    logic t;
    logic [10:0] cap;
    rbo = '0;
    jtag.enable_i = 1'b1;
    jtag.shift_dr_capture_dr_i = 1'b1;
    tck_pulse(1'b0, t);
    cap = {exp_err, 2'b00, exp_dout};
    for (int k = 0; k < n; k++) begin
      tck_pulse(bits[k], t);
      if (k < 11) begin
        rbo[k] = t;
        chk("tdo", 32'(t), 32'(cap[k]));
      end
      if (abort != 0 && k + 1 == cut) break;
    end
    if (abort == 1) begin
      #100 jtag.tlr_i = 1'b1;
      #300 jtag.tlr_i = 1'b0;
      jtag.enable_i = 1'b0;
      jtag.shift_dr_capture_dr_i = 1'b0;
    end else if (abort == 2) begin
      #61 rst_n = 1'b0;
      exp_dout = 8'h00; exp_err = 1'b0; exp_cnt = 8'h00; exp_valid = 1'b0; exp_pulse = 8'h00; pend = 0;
      #1 chk("async reset dout", 32'(dout), 32'h00);
      jtag.enable_i = 1'b0;
      jtag.shift_dr_capture_dr_i = 1'b0;
      #99 rst_n = 1'b1;
    end else begin
      jtag.shift_dr_capture_dr_i = 1'b0;
      #100 jtag.update_dr_i = 1'b1;
      pend_bits = bits;
      pend_n = n;
      pend = 4;
      #500 jtag.update_dr_i = 1'b0;
      jtag.enable_i = 1'b0;
    end
    #300;
  endtask

  initial begin
    jtag.tck_i = 1'b0; jtag.tdi_i = 1'b0; jtag.enable_i = 1'b0;
    jtag.shift_dr_capture_dr_i = 1'b0; jtag.update_dr_i = 1'b0; jtag.tlr_i = 1'b0;
    #3 rst_n = 1'b0;
    check_en = 1'b1;
    #54 rst_n = 1'b1;
    #300;
    chk("reset dout", 32'(dout), 32'h00);
    chk("reset tdo", 32'(jtag.tdo_o), 32'h0);
    chk("reset err_cnt", 32'(err_cnt), 32'h00);
    // WRITE 0xA5
    valid_seen = 0;
    frame(16'h05A5, 11, 0, 0, rb);
    chk("write A5 dout", 32'(dout), 32'hA5);
    chk("write A5 valid count", 32'(valid_seen), 32'd1);
    chk("write A5 err_cnt", 32'(err_cnt), 32'h00);
    // Readback via NOP
    frame(16'h0000, 11, 0, 0, rb);
    chk("readback seq", 32'(rb), 32'h0A5);
    chk("readback dout", 32'(dout), 32'hA5);
    // Parity error, short, long, then CLEAR
    frame(16'h013C, 11, 0, 0, rb);
    chk("parity dout", 32'(dout), 32'hA5);
    chk("parity err_o", 32'(err_o), 32'h1);
    chk("parity err_cnt", 32'(err_cnt), 32'd1);
    frame(16'h05A5, 10, 0, 0, rb);
    frame(16'h05A5, 12, 0, 0, rb);
    chk("short/long err_cnt", 32'(err_cnt), 32'd3);
    frame(16'h0300, 11, 0, 0, rb);
    chk("clear err_o", 32'(err_o), 32'h0);
    chk("clear err_cnt", 32'(err_cnt), 32'h00);
    // PULSE 0x0F
    valid_seen = 0; pulse_seen = 0;
    frame(16'h060F, 11, 0, 0, rb);
    chk("pulse count", 32'(pulse_seen), 32'd1);
    chk("pulse value", 32'(pulse_val), 32'h0F);
    chk("pulse no valid", 32'(valid_seen), 32'd0);
    chk("pulse dout", 32'(dout), 32'hA5);
    // Update without shift is ignored
    jtag.enable_i = 1'b1;
    #100 jtag.update_dr_i = 1'b1;
    #500 jtag.update_dr_i = 1'b0;
    jtag.enable_i = 1'b0;
    #300 chk("idle update err_cnt", 32'(err_cnt), 32'h00);
    // TLR after 5 shifts, then normal write 0x11
    valid_seen = 0; pulse_seen = 0;
    frame(16'h0511, 11, 1, 5, rb);
    chk("tlr err_o", 32'(err_o), 32'h0);
    chk("tlr err_cnt", 32'(err_cnt), 32'h00);
    chk("tlr no strobe", 32'(valid_seen + pulse_seen), 32'd0);
    chk("tlr dout", 32'(dout), 32'hA5);
    frame(16'h0511, 11, 0, 0, rb);
    chk("write 11 dout", 32'(dout), 32'h11);
    // Async reset mid-shift, then write 0x77
    frame(16'h0577, 11, 2, 4, rb);
    chk("post reset dout", 32'(dout), 32'h00);
    valid_seen = 0;
    frame(16'h0577, 11, 0, 0, rb);
    chk("write 77 dout", 32'(dout), 32'h77);
    chk("write 77 valid count", 32'(valid_seen), 32'd1);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
